// File: rtl/sync_arb_pkg.sv
// Shared types and helpers for the synchronized round-robin arbiter.
package sync_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_W = 8;

    // Sized for the widest legal configuration (8 requesters). The search
    // starts at ptr+1 and wraps, so ptr itself has the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [7:0] cand,
                                           input logic [2:0] ptr,
                                           input int         n);
        int idx;
        rr_pick = ptr;
        for (int off = 8; off >= 1; off--) begin
            if (off <= n) begin
                idx = (int'(ptr) + off) % n;
                if (cand[idx[2:0]]) rr_pick = idx[2:0];
            end
        end
    endfunction

endpackage

// File: rtl/sync_arb_req_stage.sv
// One-bit request synchronizer with rising-edge detect.
// SYNC_ARB_3STAGE_EN selects a three-flop chain instead of two.
module sync_req_stage (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic sync_q;
    logic sync_d;

`ifdef SYNC_ARB_3STAGE_EN
    logic s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sync_q = s3;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
        end
    end

    assign sync_q = s2;
`endif

    // Edge-history flop: a held level does not re-request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_d <= 1'b0;
        else     sync_d <= sync_q;
    end

    assign rise = sync_q & ~sync_d;

endmodule

// File: rtl/sync_rr_arbiter.sv
// Round-robin arbiter for asynchronous request lines with done/timeout release.
// Build with SYNC_ARB_3STAGE_EN for three-flop request synchronizers.
module sync_rr_arbiter
    import sync_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         async_req,
    input  logic                       done,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    output logic [NUM_REQ-1:0]         pending
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [NUM_REQ-1:0]   rise;
    logic [7:0]           cand8;
    logic [2:0]           ptr3;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      pick_id;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [NUM_REQ-1:0]   clr;
    logic [TIMEOUT_W-1:0] cnt;
    logic                 do_grant;
    logic                 do_release;
    logic                 to_fire;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
        sync_req_stage u_sync (
            .clk      (clk),
            .rst      (rst),
            .async_in (async_req[i]),
            .rise     (rise[i])
        );
    end

    always_comb begin
        cand8              = '0;
        cand8[NUM_REQ-1:0] = pending | rise;
        ptr3               = '0;
        ptr3[ID_W-1:0]     = ptr;
    end

    assign pick_id = ID_W'(rr_pick(cand8, ptr3, NUM_REQ));
    assign pick_oh = NUM_REQ'(1) << pick_id;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cand8 != '0) state_nxt = GRANT;
            GRANT:   if (done || cnt == CNT_LAST) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output strobes; done takes precedence over an expiring counter.
    always_comb begin
        do_grant   = (state == IDLE) && (cand8 != '0);
        do_release = (state == RELEASE);
        to_fire    = (state == GRANT) && !done && (cnt == CNT_LAST);
        clr        = do_grant ? pick_oh : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= '0;
            grant_id    <= '0;
            ptr         <= ID_W'(NUM_REQ - 1);
            cnt         <= '0;
            timeout_err <= 1'b0;
            pending     <= '0;
        end else begin
            timeout_err <= to_fire;
            // A fresh edge consumed by this grant is not latched; a
            // re-request on top of an already-pending bit survives the clear.
            pending     <= (pending & ~clr) | (rise & ~(clr & ~pending));
            if (do_grant) begin
                grant    <= pick_oh;
                grant_id <= pick_id;
            end else if (do_release) begin
                grant <= '0;
                ptr   <= grant_id;
            end
            if (do_release)
                cnt <= '0;
            else if (state == GRANT && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Self-checking bench for sync_rr_arbiter: vector table plus corner-case sequences.
module tb_sync_rr_arbiter;

`ifdef SYNC_ARB_3STAGE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] async_req = 4'b0000;
    logic       done = 1'b0;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout_err;
    logic [3:0] pending;

    sync_rr_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .async_req   (async_req),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .pending     (pending)
    );

    always #5 tb_clk = ~tb_clk;

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] n;
        logic [7:0] ids;
    } vec_t;

    vec_t       tbl [5];
    logic [1:0] exp_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       mon_off = 1'b0;
    logic       gv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every new grant must match the oldest expected requester.
    always @(negedge tb_clk) begin
        if (!mon_off && grant_valid && !gv_prev) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected: got grant %b expected none", grant);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                check("sb_grant", 32'(grant), 32'(4'b0001 << e));
                check("sb_id", 32'(grant_id), 32'(e));
            end
        end
        gv_prev <= grant_valid;
    end

    task automatic do_reset();
        rst = 1'b1;
        async_req = 4'b0000;
        done = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge tb_clk);
        @(negedge tb_clk);
        rst = 1'b0;
        repeat (4) @(negedge tb_clk);
    endtask

    task automatic wait_grant(output int lows);
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            if (grant_valid) return;
            @(negedge tb_clk);
            lows++;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_grant: got no grant expected one within 40 cycles");
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge tb_clk);
        done = 1'b0;
    endtask

    initial begin
        int         lows;
        logic [1:0] gid;

        tbl[0] = {4'b1111, 3'd4, 2'd3, 2'd2, 2'd1, 2'd0};
        tbl[1] = {4'b0101, 3'd2, 2'd0, 2'd0, 2'd2, 2'd0};
        tbl[2] = {4'b1010, 3'd2, 2'd0, 2'd0, 2'd3, 2'd1};
        tbl[3] = {4'b1000, 3'd1, 2'd0, 2'd0, 2'd0, 2'd3};
        tbl[4] = {4'b0110, 3'd2, 2'd0, 2'd0, 2'd2, 2'd1};

        // Reset with all lines high: nothing granted or latched.
        async_req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            @(negedge tb_clk);
            check("rst_grant", 32'(grant), 0);
            check("rst_pending", 32'(pending), 0);
            check("rst_timeout", 32'(timeout_err), 0);
            check("rst_id", 32'(grant_id), 0);
        end
        #2 rst = 1'b0;
        async_req = 4'b0000;
        for (int c = 0; c < 6; c++) begin
            @(negedge tb_clk);
            check("post_rst_idle", 32'(grant_valid), 0);
        end

        // Single request latency.
        @(posedge tb_clk);
        #3 async_req[2] = 1'b1;
        exp_q.push_back(2'd2);
        @(posedge tb_clk);
        for (int i = 1; i < LAT; i++) begin
            @(posedge tb_clk);
            #1 check("lat_early", 32'(grant), 0);
        end
        @(posedge tb_clk);
        #1;
        check("lat_grant", 32'(grant), 32'(4'b0100));
        check("lat_id", 32'(grant_id), 2);
        check("lat_valid", 32'(grant_valid), 1);
        check("lat_pending", 32'(pending), 0);
        @(negedge tb_clk);
        pulse_done();
        @(negedge tb_clk);
        check("single_release", 32'(grant), 0);
        check("single_id_keep", 32'(grant_id), 2);
        async_req = 4'b0000;

        // Vector table: round-robin order from a fresh reset.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            @(posedge tb_clk);
            #3 async_req = tbl[t].mask;
            for (int j = 0; j < int'(tbl[t].n); j++)
                exp_q.push_back(tbl[t].ids[2*j +: 2]);
            for (int j = 0; j < int'(tbl[t].n); j++) begin
                wait_grant(lows);
                if (j > 0) check("rr_gap", 32'(lows), 1);
                if (j == int'(tbl[t].n) - 1) check("rr_pending_end", 32'(pending), 0);
                gid = grant_id;
                pulse_done();
                check("rr_release_hold", 32'(grant_valid), 1);
                @(negedge tb_clk);
                check("rr_release", 32'(grant), 0);
                check("rr_id_keep", 32'(grant_id), 32'(gid));
            end
            async_req = 4'b0000;
        end

        // Timeout without done, then done in the expiring cycle.
        do_reset();
        @(posedge tb_clk);
        #3 async_req[1] = 1'b1;
        exp_q.push_back(2'd1);
        wait_grant(lows);
        for (int j = 1; j <= 16; j++) begin
            @(negedge tb_clk);
            if (j < 16) begin
                check("to_err_low", 32'(timeout_err), 0);
                check("to_grant_held", 32'(grant), 32'(4'b0010));
            end else begin
                check("to_err_pulse", 32'(timeout_err), 1);
            end
        end
        @(negedge tb_clk);
        check("to_err_one_cycle", 32'(timeout_err), 0);
        check("to_grant_drop", 32'(grant), 0);
        async_req[1] = 1'b0;
        repeat (3) @(negedge tb_clk);
        async_req[1] = 1'b1;
        exp_q.push_back(2'd1);
        wait_grant(lows);
        repeat (15) @(negedge tb_clk);
        pulse_done();
        check("to_done_wins", 32'(timeout_err), 0);
        check("to_done_hold", 32'(grant_valid), 1);
        @(negedge tb_clk);
        check("to_done_err", 32'(timeout_err), 0);
        check("to_done_drop", 32'(grant), 0);
        async_req = 4'b0000;

        // Re-request during grant, alone and with another candidate.
        do_reset();
        @(posedge tb_clk);
        #3 async_req[3] = 1'b1;
        exp_q.push_back(2'd3);
        wait_grant(lows);
        repeat (2) @(negedge tb_clk);
        async_req[3] = 1'b0;
        repeat (3) @(negedge tb_clk);
        async_req[3] = 1'b1;
        exp_q.push_back(2'd3);
        repeat (4) @(negedge tb_clk);
        check("rereq_pending", 32'(pending), 32'(4'b1000));
        check("rereq_no_preempt", 32'(grant), 32'(4'b1000));
        pulse_done();
        @(negedge tb_clk);
        wait_grant(lows);
        check("rereq_pending_clr", 32'(pending), 0);
        async_req[0] = 1'b1;
        exp_q.push_back(2'd0);
        async_req[3] = 1'b0;
        repeat (3) @(negedge tb_clk);
        async_req[3] = 1'b1;
        exp_q.push_back(2'd3);
        repeat (4) @(negedge tb_clk);
        check("rereq_pending2", 32'(pending), 32'(4'b1001));
        pulse_done();
        @(negedge tb_clk);
        wait_grant(lows);
        pulse_done();
        @(negedge tb_clk);
        wait_grant(lows);
        check("rereq_last_id", 32'(grant_id), 3);

        // Asynchronous reset while granted.
        #2 rst = 1'b1;
        #1;
        check("arst_grant", 32'(grant), 0);
        check("arst_valid", 32'(grant_valid), 0);
        check("arst_pending", 32'(pending), 0);
        do_reset();

        // Unknown level on a request line.
        mon_off = 1'b1;
        async_req[0] = 1'bx;
        for (int c = 0; c < 20; c++) begin
            @(negedge tb_clk);
            if (c >= 2) begin
                check("x_grant", 32'($isunknown(grant)), 0);
                check("x_pending", 32'($isunknown(pending)), 0);
                check("x_valid", 32'($isunknown(grant_valid)), 0);
            end
        end
        async_req[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (grant_valid) pulse_done();
            else @(negedge tb_clk);
        end
        do_reset();
        mon_off = 1'b0;

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
